// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if: ID-stage instruction, flush and stall handshake plus the
// per-stage control outputs that the decode pipeline drives into the datapath.
interface decode_ctrl_pipe_if #(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 5
);
  // ID-stage side
  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic               flush_i;
  logic               stall_o;

  // EX-stage controls
  logic               ex_valid_o;
  logic [2:0]         ex_aluop_o;
  logic               ex_alusrc_o;
  logic               ex_branch_o;
  logic [1:0]         ex_branchtype_o;
  logic               ex_jump_o;
  logic [REG_W-1:0]   ex_dest_o;
  logic               ex_illegal_o;

  // MEM-stage controls
  logic               mem_memread_o;
  logic               mem_memwrite_o;

  // WB-stage controls
  logic               wb_regwrite_o;
  logic               wb_memtoreg_o;
  logic               wb_link_o;
  logic [REG_W-1:0]   wb_dest_o;

  // Upstream (fetch / IF-ID register) and datapath view.
  modport master (
    output instr_i, instr_valid_i, flush_i,
    input  stall_o,
    input  ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_branchtype_o,
    input  ex_jump_o, ex_dest_o, ex_illegal_o,
    input  mem_memread_o, mem_memwrite_o,
    input  wb_regwrite_o, wb_memtoreg_o, wb_link_o, wb_dest_o
  );

  // Decode pipeline view.
  modport slave (
    input  instr_i, instr_valid_i, flush_i,
    output stall_o,
    output ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_branchtype_o,
    output ex_jump_o, ex_dest_o, ex_illegal_o,
    output mem_memread_o, mem_memwrite_o,
    output wb_regwrite_o, wb_memtoreg_o, wb_link_o, wb_dest_o
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: decodes the ID-stage opcode into the full control set and
// carries the control groups through registered EX, MEM and WB stages. A
// load-use hazard against the instruction in EX raises a one-cycle stall;
// a flush or a stall inserts a bubble into EX. Back stages never stall.
module decode_ctrl_pipe #(
  parameter int INSTR_W   = 32,
  parameter int OP_W      = 6,
  parameter int REG_W     = 5,
  parameter int LINK_REG  = 31,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  decode_ctrl_pipe_if.slave bus
);

  // Instruction field positions: opcode at the top, then rs, rt, rd.
  localparam int RS_LSB = INSTR_W - OP_W - REG_W;
  localparam int RT_LSB = RS_LSB - REG_W;
  localparam int RD_LSB = RT_LSB - REG_W;

  // Opcodes (MIPS standard, plus the custom bge/bgt encodings).
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_BGT   = OP_W'(6'b000111);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  // ALUOp encoding shared with the existing ALU control block.
  localparam logic [2:0] ALU_RTYPE  = 3'b000;
  localparam logic [2:0] ALU_MEM    = 3'b001;
  localparam logic [2:0] ALU_BRANCH = 3'b010;
  localparam logic [2:0] ALU_ADDI   = 3'b011;
  localparam logic [2:0] ALU_SLTI   = 3'b100;
  localparam logic [2:0] ALU_JUMP   = 3'b101;

  // Branch-type encoding seen by the branch comparator.
  localparam logic [1:0] BT_BEQ = 2'b00;
  localparam logic [1:0] BT_BGT = 2'b01;
  localparam logic [1:0] BT_BGE = 2'b10;
  localparam logic [1:0] BT_BNE = 2'b11;

  // Full control set as held in EX; later stages keep only what they use.
  typedef struct packed {
    logic             valid;
    logic [2:0]       aluOp;
    logic             aluSrc;
    logic             branch;
    logic [1:0]       branchType;
    logic             jump;
    logic [REG_W-1:0] dest;
    logic             illegal;
    logic             memRead;
    logic             memWrite;
    logic             regWrite;
    logic             memToReg;
    logic             link;
  } exCtrl_t;

  typedef struct packed {
    logic             memRead;
    logic             memWrite;
    logic             regWrite;
    logic             memToReg;
    logic             link;
    logic [REG_W-1:0] dest;
  } memCtrl_t;

  typedef struct packed {
    logic             regWrite;
    logic             memToReg;
    logic             link;
    logic [REG_W-1:0] dest;
  } wbCtrl_t;

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             usesRt;
  logic             hazard;

  exCtrl_t  decoded;
  exCtrl_t  qualified;
  exCtrl_t  exNext;
  exCtrl_t  exReg;
  memCtrl_t memReg;
  wbCtrl_t  wbReg;

  assign opcode = bus.instr_i[INSTR_W-1 -: OP_W];
  assign rs     = bus.instr_i[RS_LSB +: REG_W];
  assign rt     = bus.instr_i[RT_LSB +: REG_W];
  assign rd     = bus.instr_i[RD_LSB +: REG_W];

  // Immediate / shamt / funct bits are not needed for main control.
  logic unusedLowBits;
  assign unusedLowBits = ^bus.instr_i[RD_LSB-1:0];

  // Opcode decode; unknown opcodes give all-zero controls with illegal set.
  always_comb begin
    decoded       = '0;
    decoded.valid = 1'b1;
    decoded.dest  = rt;
    usesRt        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decoded.aluOp    = ALU_RTYPE;
        decoded.regWrite = 1'b1;
        decoded.dest     = rd;
        usesRt           = 1'b1;
      end
      OP_LW: begin
        decoded.aluOp    = ALU_MEM;
        decoded.aluSrc   = 1'b1;
        decoded.memRead  = 1'b1;
        decoded.memToReg = 1'b1;
        decoded.regWrite = 1'b1;
      end
      OP_SW: begin
        decoded.aluOp    = ALU_MEM;
        decoded.aluSrc   = 1'b1;
        decoded.memWrite = 1'b1;
        usesRt           = 1'b1;
      end
      OP_BEQ: begin
        decoded.aluOp      = ALU_BRANCH;
        decoded.branch     = 1'b1;
        decoded.branchType = BT_BEQ;
        usesRt             = 1'b1;
      end
      OP_BGT: begin
        decoded.aluOp      = ALU_BRANCH;
        decoded.branch     = 1'b1;
        decoded.branchType = BT_BGT;
        usesRt             = 1'b1;
      end
      OP_BGE: begin
        decoded.aluOp      = ALU_BRANCH;
        decoded.branch     = 1'b1;
        decoded.branchType = BT_BGE;
        usesRt             = 1'b1;
      end
      OP_BNE: begin
        decoded.aluOp      = ALU_BRANCH;
        decoded.branch     = 1'b1;
        decoded.branchType = BT_BNE;
        usesRt             = 1'b1;
      end
      OP_ADDI: begin
        decoded.aluOp    = ALU_ADDI;
        decoded.aluSrc   = 1'b1;
        decoded.regWrite = 1'b1;
      end
      OP_SLTI: begin
        decoded.aluOp    = ALU_SLTI;
        decoded.aluSrc   = 1'b1;
        decoded.regWrite = 1'b1;
      end
      OP_J: begin
        decoded.aluOp = ALU_JUMP;
        decoded.jump  = 1'b1;
      end
      OP_JAL: begin
        decoded.aluOp    = ALU_JUMP;
        decoded.jump     = 1'b1;
        decoded.regWrite = 1'b1;
        decoded.link     = 1'b1;
        decoded.dest     = REG_W'(LINK_REG);
      end
      default: begin
        // Keep valid so the datapath can trap on the illegal instruction.
        decoded.dest    = '0;
        decoded.illegal = 1'b1;
      end
    endcase
  end

  // An empty IF/ID slot decodes to a pure bubble, illegal flag included.
  assign qualified = bus.instr_valid_i ? decoded : '0;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // A flushed ID instruction is dead, so it never stalls.
  generate
    if (HAZARD_EN) begin : genHazard
      always_comb begin
        hazard = bus.instr_valid_i & ~bus.flush_i & exReg.valid & exReg.memRead &
                 (exReg.dest != '0) &
                 ((exReg.dest == rs) | (usesRt & (exReg.dest == rt)));
      end
    end else begin : genNoHazard
      logic unusedHazardInputs;
      assign unusedHazardInputs = ^{rs, usesRt};
      assign hazard = 1'b0;
    end
  endgenerate

  assign bus.stall_o = hazard;

  // EX input: flush beats stall, both insert a bubble.
  always_comb begin
    exNext = qualified;
    if (bus.flush_i || hazard) begin
      exNext = '0;
    end
  end

  // EX stage register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exReg <= '0;
    end else begin
      exReg <= exNext;
    end
  end

  // MEM stage register: advances every cycle; illegal is dropped here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memReg <= '0;
    end else begin
      memReg.memRead  <= exReg.memRead;
      memReg.memWrite <= exReg.memWrite;
      memReg.regWrite <= exReg.regWrite;
      memReg.memToReg <= exReg.memToReg;
      memReg.link     <= exReg.link;
      memReg.dest     <= exReg.dest;
    end
  end

  // WB stage register: advances every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbReg <= '0;
    end else begin
      wbReg.regWrite <= memReg.regWrite;
      wbReg.memToReg <= memReg.memToReg;
      wbReg.link     <= memReg.link;
      wbReg.dest     <= memReg.dest;
    end
  end

  assign bus.ex_valid_o      = exReg.valid;
  assign bus.ex_aluop_o      = exReg.aluOp;
  assign bus.ex_alusrc_o     = exReg.aluSrc;
  assign bus.ex_branch_o     = exReg.branch;
  assign bus.ex_branchtype_o = exReg.branchType;
  assign bus.ex_jump_o       = exReg.jump;
  assign bus.ex_dest_o       = exReg.dest;
  assign bus.ex_illegal_o    = exReg.illegal;

  assign bus.mem_memread_o   = memReg.memRead;
  assign bus.mem_memwrite_o  = memReg.memWrite;

  assign bus.wb_regwrite_o   = wbReg.regWrite;
  assign bus.wb_memtoreg_o   = wbReg.memToReg;
  assign bus.wb_link_o       = wbReg.link;
  assign bus.wb_dest_o       = wbReg.dest;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: table of single-instruction decode vectors, hand-written
// hazard/flush/reset sequences, then a random stream against a reference model.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.INSTR_W(32), .REG_W(5)) bus ();
  decode_ctrl_pipe_if #(.INSTR_W(32), .REG_W(5)) busNh ();

  // The hazard-disabled copy sees exactly the same ID-stage stimulus.
  assign busNh.instr_i       = bus.instr_i;
  assign busNh.instr_valid_i = bus.instr_valid_i;
  assign busNh.flush_i       = bus.flush_i;

  decode_ctrl_pipe #(.INSTR_W(32), .OP_W(6), .REG_W(5), .LINK_REG(31), .HAZARD_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));
  decode_ctrl_pipe #(.INSTR_W(32), .OP_W(6), .REG_W(5), .LINK_REG(31), .HAZARD_EN(1'b0)) dutNh (
    .clk_i(clk), .rst_i(rst), .bus(busNh));

  logic [14:0] exAct;
  logic [1:0]  memAct;
  logic [7:0]  wbAct;
  logic [25:0] allAct;
  assign exAct  = {bus.ex_valid_o, bus.ex_aluop_o, bus.ex_alusrc_o, bus.ex_branch_o,
                   bus.ex_branchtype_o, bus.ex_jump_o, bus.ex_dest_o, bus.ex_illegal_o};
  assign memAct = {bus.mem_memread_o, bus.mem_memwrite_o};
  assign wbAct  = {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_link_o, bus.wb_dest_o};
  assign allAct = {bus.stall_o, exAct, memAct, wbAct};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic f);
    bus.instr_i       = ins;
    bus.instr_valid_i = v;
    bus.flush_i       = f;
    #1;
  endtask

  function automatic logic [14:0] mkEx(input logic v, input logic [2:0] op, input logic src,
                                       input logic br, input logic [1:0] bt, input logic j,
                                       input logic [4:0] d, input logic ill);
    return {v, op, src, br, bt, j, d, ill};
  endfunction

  function automatic logic [7:0] mkWb(input logic rw, input logic m2r, input logic lk,
                                      input logic [4:0] d);
    return {rw, m2r, lk, d};
  endfunction

  // Reference model: control record derived from the opcode table.
  typedef struct packed {
    logic       valid;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       branch;
    logic [1:0] bType;
    logic       jump;
    logic [4:0] dest;
    logic       illegal;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic       link;
  } ctl_t;

  function automatic ctl_t refDecode(input logic [31:0] ins, input logic v);
    ctl_t c;
    logic [5:0] op;
    c  = '0;
    op = ins[31:26];
    if (!v) return c;
    c.valid = 1'b1;
    c.dest  = ins[20:16];
    case (op)
      6'h00: begin c.dest = ins[15:11]; c.regWrite = 1'b1; end
      6'h23: begin c.aluOp = 3'd1; c.aluSrc = 1'b1; c.memRead = 1'b1;
                   c.memToReg = 1'b1; c.regWrite = 1'b1; end
      6'h2B: begin c.aluOp = 3'd1; c.aluSrc = 1'b1; c.memWrite = 1'b1; end
      6'h04: begin c.aluOp = 3'd2; c.branch = 1'b1; c.bType = 2'b00; end
      6'h07: begin c.aluOp = 3'd2; c.branch = 1'b1; c.bType = 2'b01; end
      6'h01: begin c.aluOp = 3'd2; c.branch = 1'b1; c.bType = 2'b10; end
      6'h05: begin c.aluOp = 3'd2; c.branch = 1'b1; c.bType = 2'b11; end
      6'h08: begin c.aluOp = 3'd3; c.aluSrc = 1'b1; c.regWrite = 1'b1; end
      6'h0A: begin c.aluOp = 3'd4; c.aluSrc = 1'b1; c.regWrite = 1'b1; end
      6'h02: begin c.aluOp = 3'd5; c.jump = 1'b1; end
      6'h03: begin c.aluOp = 3'd5; c.jump = 1'b1; c.regWrite = 1'b1;
                   c.link = 1'b1; c.dest = 5'd31; end
      default: begin c.dest = 5'd0; c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

  function automatic logic refStall(input ctl_t ex, input logic [31:0] ins,
                                    input logic v, input logic f);
    logic usesRt;
    usesRt = ins[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05, 6'h01, 6'h07};
    return v && !f && ex.valid && ex.memRead && (ex.dest != 5'd0) &&
           ((ex.dest == ins[25:21]) || (usesRt && (ex.dest == ins[20:16])));
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [14:0] ex;
    logic [1:0]  mem;
    logic [7:0]  wb;
  } vec_t;

  localparam logic [31:0] LW8   = 32'h8D280000;  // lw  $8,0($9)
  localparam logic [31:0] ADDR8 = 32'h010B5020;  // add $10,$8,$11
  localparam logic [31:0] LW0   = 32'h8D200000;  // lw  $0,0($9)
  localparam logic [31:0] ADDR0 = 32'h000B5020;  // add $10,$0,$11
  localparam logic [31:0] BGE   = 32'h05280003;
  localparam logic [31:0] BNE   = 32'h15280003;

  vec_t vecs[12];
  logic [5:0] ops[12];
  ctl_t hist[$];

  initial begin
    vecs[0]  = '{"addi",  32'h21280005, mkEx(1, 3'b011, 1, 0, 2'b00, 0, 5'd8,  0), 2'b00, mkWb(1, 0, 0, 5'd8)};
    vecs[1]  = '{"add",   32'h012B5020, mkEx(1, 3'b000, 0, 0, 2'b00, 0, 5'd10, 0), 2'b00, mkWb(1, 0, 0, 5'd10)};
    vecs[2]  = '{"lw",    32'h8D280000, mkEx(1, 3'b001, 1, 0, 2'b00, 0, 5'd8,  0), 2'b10, mkWb(1, 1, 0, 5'd8)};
    vecs[3]  = '{"sw",    32'hAD280004, mkEx(1, 3'b001, 1, 0, 2'b00, 0, 5'd8,  0), 2'b01, mkWb(0, 0, 0, 5'd8)};
    vecs[4]  = '{"beq",   32'h11280003, mkEx(1, 3'b010, 0, 1, 2'b00, 0, 5'd8,  0), 2'b00, mkWb(0, 0, 0, 5'd8)};
    vecs[5]  = '{"bgt",   32'h1D280003, mkEx(1, 3'b010, 0, 1, 2'b01, 0, 5'd8,  0), 2'b00, mkWb(0, 0, 0, 5'd8)};
    vecs[6]  = '{"bge",   32'h05280003, mkEx(1, 3'b010, 0, 1, 2'b10, 0, 5'd8,  0), 2'b00, mkWb(0, 0, 0, 5'd8)};
    vecs[7]  = '{"bne",   32'h15280003, mkEx(1, 3'b010, 0, 1, 2'b11, 0, 5'd8,  0), 2'b00, mkWb(0, 0, 0, 5'd8)};
    vecs[8]  = '{"slti",  32'h29280007, mkEx(1, 3'b100, 1, 0, 2'b00, 0, 5'd8,  0), 2'b00, mkWb(1, 0, 0, 5'd8)};
    vecs[9]  = '{"j",     32'h08000010, mkEx(1, 3'b101, 0, 0, 2'b00, 1, 5'd0,  0), 2'b00, mkWb(0, 0, 0, 5'd0)};
    vecs[10] = '{"jal",   32'h0C000010, mkEx(1, 3'b101, 0, 0, 2'b00, 1, 5'd31, 0), 2'b00, mkWb(1, 0, 1, 5'd31)};
    vecs[11] = '{"illeg", 32'hFC000000, mkEx(1, 3'b000, 0, 0, 2'b00, 0, 5'd0,  1), 2'b00, mkWb(0, 0, 0, 5'd0)};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h01, 6'h07, 6'h08, 6'h0A, 6'h02, 6'h03, 6'h3F};

    // Reset state, before any clock edge.
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
    chk("reset_state", 32'(allAct), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_nh_stall", 32'(busNh.stall_o), 32'h0);

    // Decode table: one instruction, then bubbles while it drains to WB.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].instr, 1'b1, 1'b0);
      chk({vecs[i].name, "_stall"}, 32'(bus.stall_o), 32'h0);
      tick();
      chk({vecs[i].name, "_ex"}, 32'(exAct), 32'(vecs[i].ex));
      drive(vecs[i].instr, 1'b0, 1'b0);
      tick();
      chk({vecs[i].name, "_mem"}, 32'(memAct), 32'(vecs[i].mem));
      chk({vecs[i].name, "_bubble"}, 32'(exAct), 32'h0);
      tick();
      chk({vecs[i].name, "_wb"}, 32'(wbAct), 32'(vecs[i].wb));
    end

    // Load-use: one stall cycle, bubble between lw and add.
    drive(LW8, 1'b1, 1'b0);
    tick();
    drive(ADDR8, 1'b1, 1'b0);
    chk("lu_stall", 32'(bus.stall_o), 32'h1);
    chk("lu_nh_stall", 32'(busNh.stall_o), 32'h0);
    tick();
    chk("lu_ex_bubble", 32'(exAct), 32'h0);
    chk("lu_mem_lw", 32'(memAct), 32'h2);
    chk("lu_nh_ex_add", 32'({busNh.ex_valid_o, busNh.ex_dest_o}), 32'h2A);
    chk("lu_stall_clear", 32'(bus.stall_o), 32'h0);
    tick();
    chk("lu_ex_add", 32'(exAct), 32'(mkEx(1, 3'b000, 0, 0, 2'b00, 0, 5'd10, 0)));
    drive(32'h0, 1'b0, 1'b0);
    tick();
    tick();

    // Load into $0 never creates a hazard.
    drive(LW0, 1'b1, 1'b0);
    tick();
    drive(ADDR0, 1'b1, 1'b0);
    chk("lw0_stall", 32'(bus.stall_o), 32'h0);
    tick();
    chk("lw0_ex_add", 32'({bus.ex_valid_o, bus.ex_dest_o}), 32'h2A);
    drive(32'h0, 1'b0, 1'b0);
    tick();

    // Flush wins over a pending hazard.
    drive(LW8, 1'b1, 1'b0);
    tick();
    drive(ADDR8, 1'b1, 1'b1);
    chk("flush_stall", 32'(bus.stall_o), 32'h0);
    tick();
    chk("flush_ex_bubble", 32'(exAct), 32'h0);
    drive(32'h0, 1'b0, 1'b0);
    tick();

    // Back-to-back branches.
    drive(BGE, 1'b1, 1'b0);
    tick();
    chk("bge_type", 32'({bus.ex_branch_o, bus.ex_branchtype_o}), 32'h6);
    drive(BNE, 1'b1, 1'b0);
    tick();
    chk("bne_type", 32'({bus.ex_branch_o, bus.ex_branchtype_o}), 32'h7);

    // Asynchronous reset mid-stream with a live hazard.
    drive(LW8, 1'b1, 1'b0);
    tick();
    drive(ADDR8, 1'b1, 1'b0);
    chk("mid_pre_stall", 32'(bus.stall_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_reset_all", 32'(allAct), 32'h0);
    tick();
    drive(32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Random stream against the reference model.
    begin
      logic [31:0] ins;
      logic        v;
      logic        f;
      logic        hold;
      logic        expStall;
      ctl_t        nxt;
      ctl_t        exE;
      ctl_t        memE;
      ctl_t        wbE;
      hist = {};
      repeat (3) hist.push_back(ctl_t'('0));
      hold = 1'b0;
      ins  = 32'h0;
      for (int i = 0; i < 400; i++) begin
        if (!hold) begin
          ins = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 11'($urandom)};
          v = ($urandom_range(0, 99) < 85);
        end else begin
          v = 1'b1;
        end
        f = ($urandom_range(0, 9) == 0);
        drive(ins, v, f);
        expStall = refStall(hist[hist.size()-1], ins, v, f);
        chk("rnd_stall", 32'(bus.stall_o), 32'(expStall));
        chk("rnd_nh_stall", 32'(busNh.stall_o), 32'h0);
        nxt = (f || expStall) ? ctl_t'('0) : refDecode(ins, v);
        tick();
        hist.push_back(nxt);
        exE  = hist[hist.size()-1];
        memE = hist[hist.size()-2];
        wbE  = hist[hist.size()-3];
        chk("rnd_ex", 32'(exAct), 32'(mkEx(exE.valid, exE.aluOp, exE.aluSrc, exE.branch,
                                            exE.bType, exE.jump, exE.dest, exE.illegal)));
        chk("rnd_mem", 32'(memAct), 32'({memE.memRead, memE.memWrite}));
        chk("rnd_wb", 32'(wbAct), 32'(mkWb(wbE.regWrite, wbE.memToReg, wbE.link, wbE.dest)));
        hold = expStall;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle main decoder.
- Decodes the opcode of the ID-stage instruction into the full control set (ALU, memory, writeback, branch type, jump/jal).
- Carries each control group down registered EX, MEM and WB stages.
- Detects load-use hazards and generates a stall; accepts a branch/jump flush. Sits between the IF/ID register and the datapath.

Parameters:
- INSTR_W, 32, instruction width.
- OP_W, 6, opcode width (instr[INSTR_W-1 -: OP_W]).
- REG_W, 5, register index width (rs=instr[25:21], rt=[20:16], rd=[15:11] for the default widths).
- LINK_REG, 31, destination register for jal.
- HAZARD_EN, 1, 1 = load-use stall detection enabled; 0 = stall_o tied 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_i  in  INSTR_W  ID-stage instruction.
- instr_valid_i  in  1  instr_i holds a real instruction.
- flush_i  in  1  branch taken or jump resolved; kill the ID-stage instruction.
- stall_o  out  1  load-use hazard; upstream must hold PC and IF/ID.
- ex_valid_o  out  1  EX-stage instruction valid.
- ex_aluop_o  out  3  ALUOp, using the same encoding as the existing ALU control.
- ex_alusrc_o  out  1  1 = immediate operand.
- ex_branch_o  out  1  conditional branch.
- ex_branchtype_o  out  2  beq=00, bgt=01, bge=10, bne=11.
- ex_jump_o  out  1  j or jal.
- ex_dest_o  out  REG_W  write register index.
- ex_illegal_o  out  1  valid instruction with an unknown opcode.
- mem_memread_o  out  1  MEM-stage load.
- mem_memwrite_o  out  1  MEM-stage store.
- wb_regwrite_o  out  1  WB-stage register write.
- wb_memtoreg_o  out  1  1 = writeback data from memory.
- wb_link_o  out  1  1 = writeback data is PC+4 (jal).
- wb_dest_o  out  REG_W  WB write register index.

Behaviour:
- Decode is combinational, default-complete (no latches). Unknown opcode yields all controls 0 with illegal=1.
- ALUOp per opcode: R-type 000; lw/sw 001; beq/bne/bge/bgt 010; addi 011; slti 100; j/jal 101.
- ALUSrc = lw|sw|addi|slti. MemToReg = lw. MemRead = lw. MemWrite = sw.
- RegWrite = rtype|addi|slti|lw|jal.
- dest: rd for R-type, LINK_REG for jal, rt otherwise.
- Branch = beq|bne|bge|bgt. Opcodes: bge 000001, bgt 000111, others MIPS standard.
- Decoded controls are qualified by instr_valid_i. Invalid input gives a bubble: all controls 0, including illegal.
- Each rising edge, in priority order:
  - flush_i=1: EX loads a bubble.
  - else stall_o=1: EX loads a bubble.
  - else EX loads the qualified decode.
- MEM loads EX and WB loads MEM unconditionally every cycle; the back stages never stall.
- Latency: instruction at ID in cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3.
- stall_o (combinational) = HAZARD_EN & instr_valid_i & ~flush_i & ex_valid & ex_memread & (ex_dest!=0) & (ex_dest==rs | (uses_rt & ex_dest==rt)).
  - uses_rt = R-type|sw|beq|bne|bge|bgt.
  - A stall lasts exactly one cycle: the next cycle EX holds a bubble, so the hazard clears.
- flush_i and a hazard in the same cycle: flush wins, stall_o=0, EX gets a bubble.
- Reset (asynchronous, mid-operation included): every stage register and every output clears to 0 immediately; stall_o=0.
- Illegal flag travels with EX only and is not carried further.

Test Plan:
- Reset pulse mid-stream → all outputs 0 within the same cycle, with no clock edge required.
- addi $8,$9,5 (0x21280005) valid → ex_aluop=011, ex_alusrc=1, ex_dest=8. Two cycles later: wb_regwrite=1, wb_memtoreg=0.
- lw $8,0($9) then add $10,$8,$11 → stall_o=1 for one cycle. The add reaches EX one cycle late; a bubble (ex_valid=0) sits between them.
- lw $0,0($9) then add $10,$0,$11 → stall_o=0. Repeat the lw/add pair with HAZARD_EN=0 → stall_o=0.
- bge (op 000001) then bne → ex_branch=1 with ex_branchtype=10, then 11. flush_i with a pending hazard → stall_o=0, EX bubble.
- jal → ex_jump=1, ex_dest=31; wb_link=1, wb_regwrite=1 three cycles after ID. Opcode 111111 → ex_illegal=1, all other controls 0.
